// File: rtl/irq_ctrl.sv
// irq_ctrl: PicoBlaze interrupt controller.
//
// Captures rising edges on the request lines into a pending register,
// masks them, picks the lowest-numbered active source and drives the
// single interrupt / interrupt_ack handshake. Software reaches the
// controller through four I/O ports starting at ADDR:
//   ADDR+0 PEND   (read, write-1-to-clear)
//   ADDR+1 MASK   (read/write, 1 = enabled)
//   ADDR+2 VECTOR (read {valid, 4'b0, idx})
//   ADDR+3 EOI    (write ends service, read {7'b0, in_service})
//
// Ports:
//   clk_in        system clock, rising edge
//   rst_n         asynchronous active-low reset
//   irq_src       request lines (bit 0 = timer tmr_int)
//   address       PicoBlaze port_id
//   data_in       PicoBlaze out_port
//   wen / ren     one-cycle write / read strobes
//   data_out      combinational read data
//   interrupt     registered interrupt request to PicoBlaze
//   interrupt_ack PicoBlaze acknowledge
//   in_service    high while an interrupt is being serviced
module irq_ctrl #(
    parameter logic [7:0] ADDR = 8'h10,
    parameter int         NSRC = 8
) (
    input  logic            clk_in,
    input  logic            rst_n,
    input  logic [NSRC-1:0] irq_src,
    input  logic [7:0]      address,
    input  logic [7:0]      data_in,
    input  logic            wen,
    input  logic            ren,
    output logic [7:0]      data_out,
    output logic            interrupt,
    input  logic            interrupt_ack,
    output logic            in_service
);

    localparam logic [7:0] A_PEND = ADDR;
    localparam logic [7:0] A_MASK = ADDR + 8'd1;
    localparam logic [7:0] A_VEC  = ADDR + 8'd2;
    localparam logic [7:0] A_EOI  = ADDR + 8'd3;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        SERVICE
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [NSRC-1:0] src_d;
    logic            primed;
    logic [NSRC-1:0] pend;
    logic [NSRC-1:0] mask;
    logic [NSRC-1:0] rise;
    logic [NSRC-1:0] act;
    logic [2:0]      idx;
    logic            valid;
    logic            cur_valid;
    logic [2:0]      cur_idx;
    logic            pend_wr;
    logic            mask_wr;
    logic            eoi_wr;
    logic            unused_ren;

    // Reads have no side effects, so the read strobe is not needed.
    assign unused_ren = ren;

    // primed stays low for the first clock after reset so a line that is
    // already high at reset release only loads src_d and is not captured.
    assign rise    = irq_src & ~src_d & {NSRC{primed}};
    assign act     = pend & mask;
    assign valid   = |act;
    assign pend_wr = wen && (address == A_PEND);
    assign mask_wr = wen && (address == A_MASK);
    assign eoi_wr  = wen && (address == A_EOI);

    assign interrupt  = (state == REQ);
    assign in_service = (state == SERVICE);

    // Fixed priority: lowest set index wins, so scan from the top down.
    always_comb begin
        idx = 3'd0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (act[i]) begin
                idx = 3'(i);
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (valid)         next_state = REQ;
            REQ:     if (interrupt_ack) next_state = SERVICE;
            SERVICE: if (eoi_wr)        next_state = IDLE;
            default:                    next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A rise in the same cycle as a W1C of that bit wins.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            src_d     <= '0;
            primed    <= 1'b0;
            pend      <= '0;
            mask      <= '0;
            cur_valid <= 1'b0;
            cur_idx   <= 3'd0;
        end else begin
            src_d  <= irq_src;
            primed <= 1'b1;
            if (pend_wr) begin
                pend <= (pend & ~data_in[NSRC-1:0]) | rise;
            end else begin
                pend <= pend | rise;
            end
            if (mask_wr) begin
                mask <= data_in[NSRC-1:0];
            end
            if (state == REQ && interrupt_ack) begin
                cur_valid <= valid;
                cur_idx   <= idx;
            end
        end
    end

    always_comb begin
        data_out = 8'h00;
        case (address)
            A_PEND:  data_out = 8'(pend);
            A_MASK:  data_out = 8'(mask);
            A_VEC:   data_out = {cur_valid, 4'b0000, cur_idx};
            A_EOI:   data_out = {7'b0000000, in_service};
            default: data_out = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: scoreboard bench for irq_ctrl.
//
// Stimulus drives inputs on the falling clock edge and pushes the expected
// read data for every read strobe into a queue. A behavioural model of the
// controller (pending/mask bit sets, "requesting"/"servicing" flags) is
// advanced on every rising edge. A monitor samples shortly after the
// falling edge, compares interrupt and in_service against the model and
// pops the queue whenever a read strobe is presented.
module tb_irq_ctrl;

    localparam logic [7:0] ADDR = 8'h10;

    typedef struct {
        string      name;
        logic [7:0] val;
    } exp_t;

    logic       clk_in = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] irq_src = 8'h00;
    logic [7:0] address = 8'h00;
    logic [7:0] data_in = 8'h00;
    logic       wen = 1'b0;
    logic       ren = 1'b0;
    logic [7:0] data_out;
    logic       interrupt;
    logic       interrupt_ack = 1'b0;
    logic       in_service;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    // Behavioural model state
    logic [7:0] m_pend = 8'h00;
    logic [7:0] m_mask = 8'h00;
    logic [7:0] m_prev = 8'h00;
    bit         m_primed = 1'b0;
    bit         m_req = 1'b0;
    bit         m_svc = 1'b0;
    logic [7:0] m_vec = 8'h00;

    irq_ctrl #(.ADDR(ADDR), .NSRC(8)) dut (
        .clk_in        (clk_in),
        .rst_n         (rst_n),
        .irq_src       (irq_src),
        .address       (address),
        .data_in       (data_in),
        .wen           (wen),
        .ren           (ren),
        .data_out      (data_out),
        .interrupt     (interrupt),
        .interrupt_ack (interrupt_ack),
        .in_service    (in_service)
    );

    always #5 clk_in = ~clk_in;

    task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] model_read(input logic [7:0] a);
        case (a - ADDR)
            8'd0:    return m_pend;
            8'd1:    return m_mask;
            8'd2:    return m_vec;
            8'd3:    return {7'b0, m_svc};
            default: return 8'h00;
        endcase
    endfunction

    // Reference model: applies the controller's rules once per clock.
    always @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            m_pend = 8'h00; m_mask = 8'h00; m_prev = 8'h00;
            m_primed = 1'b0; m_req = 1'b0; m_svc = 1'b0; m_vec = 8'h00;
        end else begin
            logic [7:0] rises;
            logic [7:0] active;
            int         lowest;
            bit         any;
            rises  = 8'h00;
            active = 8'h00;
            lowest = 0;
            any    = 1'b0;
            for (int i = 0; i < 8; i++) begin
                rises[i]  = m_primed && irq_src[i] && !m_prev[i];
                active[i] = m_pend[i] && m_mask[i];
                if (active[i] && !any) begin
                    any    = 1'b1;
                    lowest = i;
                end
            end
            if (m_svc) begin
                if (wen && address == ADDR + 8'd3) m_svc = 1'b0;
            end else if (m_req) begin
                if (interrupt_ack) begin
                    m_req = 1'b0;
                    m_svc = 1'b1;
                    m_vec = any ? (8'h80 + 8'(lowest)) : 8'(lowest);
                end
            end else if (any) begin
                m_req = 1'b1;
            end
            for (int i = 0; i < 8; i++) begin
                if (wen && address == ADDR && data_in[i]) m_pend[i] = 1'b0;
                if (rises[i]) m_pend[i] = 1'b1;
            end
            if (wen && address == ADDR + 8'd1) m_mask = data_in;
            m_prev   = irq_src;
            m_primed = 1'b1;
        end
    end

    // Monitor: compares handshake outputs every cycle and read data on strobes.
    initial begin
        forever begin
            @(negedge clk_in);
            #2;
            check_output("interrupt", {7'b0, interrupt}, {7'b0, m_req});
            check_output("in_service", {7'b0, in_service}, {7'b0, m_svc});
            if (ren) begin
                if (exp_q.size() == 0) begin
                    check_output("unexpected_read", data_out, 8'hxx);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check_output(e.name, data_out, e.val);
                end
            end
        end
    end

    // One cycle of stimulus; use_const selects a fixed expected read value.
    task automatic apply_stimulus(input logic [7:0] src, input logic w, input logic r,
                                  input logic [7:0] a, input logic [7:0] d, input logic ack,
                                  input bit use_const, input logic [7:0] cval, input string name);
        @(negedge clk_in);
        irq_src       = src;
        wen           = w;
        ren           = r;
        address       = a;
        data_in       = d;
        interrupt_ack = ack;
        if (r) begin
            exp_t e;
            e.name = name;
            e.val  = use_const ? cval : model_read(a);
            exp_q.push_back(e);
        end
    endtask

    task automatic idle_cycle(input logic [7:0] src);
        apply_stimulus(src, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, "");
    endtask

    task automatic write_reg(input logic [7:0] src, input logic [7:0] a, input logic [7:0] d);
        apply_stimulus(src, 1, 0, a, d, 0, 0, 8'h00, "");
    endtask

    task automatic read_expect(input logic [7:0] src, input logic [7:0] a, input logic [7:0] v, input string name);
        apply_stimulus(src, 0, 1, a, 8'h00, 0, 1, v, name);
    endtask

    task automatic ack_cycle();
        apply_stimulus(irq_src, 0, 0, 8'h00, 8'h00, 1, 0, 8'h00, "");
    endtask

    // Bounded wait for the DUT to raise interrupt.
    task automatic wait_irq(input string name);
        for (int i = 0; i < 10 && !interrupt; i++) idle_cycle(irq_src);
        if (!interrupt) check_output(name, 8'h00, 8'h01);
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        rst_n = 1'b0;
        irq_src = 8'h00; wen = 0; ren = 0; address = 8'h00; data_in = 8'h00; interrupt_ack = 0;
        @(negedge clk_in);
        rst_n = 1'b1;
    endtask

    initial begin
        do_reset();
        read_expect(8'h00, ADDR, 8'h00, "reset_pend");
        read_expect(8'h00, ADDR + 8'd2, 8'h00, "reset_vector");

        // Timer source 0 through a full request/ack/EOI cycle
        write_reg(8'h00, ADDR + 8'd1, 8'h01);
        idle_cycle(8'h01);
        read_expect(8'h00, ADDR, 8'h01, "t1_pend");
        idle_cycle(8'h00);
        ack_cycle();
        read_expect(8'h00, ADDR + 8'd2, 8'h80, "t1_vector");
        read_expect(8'h00, ADDR + 8'd3, 8'h01, "t1_in_service");
        write_reg(8'h00, ADDR + 8'd3, 8'h00);
        read_expect(8'h00, ADDR + 8'd3, 8'h00, "t1_eoi");

        // Masked source, then unmasked
        do_reset();
        idle_cycle(8'h08);
        read_expect(8'h00, ADDR, 8'h08, "t2_pend");
        write_reg(8'h00, ADDR + 8'd1, 8'h08);
        wait_irq("t2_irq_timeout");
        ack_cycle();
        read_expect(8'h00, ADDR + 8'd2, 8'h83, "t2_vector");

        // Two simultaneous sources, priority and re-request after EOI
        do_reset();
        write_reg(8'h00, ADDR + 8'd1, 8'hFF);
        idle_cycle(8'h12);
        idle_cycle(8'h00);
        wait_irq("t3_irq_timeout");
        ack_cycle();
        read_expect(8'h00, ADDR + 8'd2, 8'h81, "t3_vector_a");
        write_reg(8'h00, ADDR, 8'h02);
        write_reg(8'h00, ADDR + 8'd3, 8'h00);
        wait_irq("t3_irq2_timeout");
        ack_cycle();
        read_expect(8'h00, ADDR + 8'd2, 8'h84, "t3_vector_b");

        // Rise beats W1C; held level does not re-set
        do_reset();
        idle_cycle(8'h01);
        idle_cycle(8'h00);
        write_reg(8'h01, ADDR, 8'h01);
        read_expect(8'h01, ADDR, 8'h01, "t4_rise_wins");
        write_reg(8'h01, ADDR, 8'h01);
        idle_cycle(8'h01);
        read_expect(8'h01, ADDR, 8'h00, "t4_level_held");

        // Periodic timer pulses, including rises during service
        do_reset();
        write_reg(8'h00, ADDR + 8'd1, 8'h01);
        for (int c = 0; c < 60; c++) begin
            logic [7:0] t;
            t = (c % 8 == 0) ? 8'h01 : 8'h00;
            if (m_req) apply_stimulus(t, 0, 0, 8'h00, 8'h00, 1, 0, 8'h00, "");
            else if (m_svc && c % 12 == 11) write_reg(t, ADDR + 8'd3, 8'h00);
            else if (c % 4 == 2) apply_stimulus(t, 0, 1, ADDR, 8'h00, 0, 0, 8'h00, "t5_pend");
            else idle_cycle(t);
        end

        // Asynchronous reset while requesting
        do_reset();
        write_reg(8'h00, ADDR + 8'd1, 8'h03);
        idle_cycle(8'h01);
        idle_cycle(8'h00);
        wait_irq("t6_irq_timeout");
        apply_stimulus(8'h00, 0, 0, ADDR + 8'd1, 8'h00, 0, 0, 8'h00, "");
        #3;
        check_output("t6_mask_before", data_out, 8'h03);
        check_output("t6_irq_before", {7'b0, interrupt}, 8'h01);
        rst_n = 1'b0;
        #1;
        check_output("t6_irq_async", {7'b0, interrupt}, 8'h00);
        check_output("t6_svc_async", {7'b0, in_service}, 8'h00);
        check_output("t6_mask_async", data_out, 8'h00);
        address = ADDR;
        #1;
        check_output("t6_pend_async", data_out, 8'h00);
        irq_src = 8'h02;
        @(negedge clk_in);
        rst_n = 1'b1;
        idle_cycle(8'h02);
        read_expect(8'h02, ADDR, 8'h00, "t6_high_at_release");

        // Randomized traffic against the model
        do_reset();
        for (int c = 0; c < 500; c++) begin
            logic [7:0] src;
            logic       w;
            logic       r;
            logic       ack;
            logic [7:0] a;
            src = irq_src;
            if ($urandom_range(0, 2) == 0) src = src ^ (8'h01 << $urandom_range(0, 7));
            w   = ($urandom_range(0, 4) == 0);
            r   = ($urandom_range(0, 2) == 0);
            a   = ADDR - 8'd1 + 8'($urandom_range(0, 5));
            ack = m_req ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 19) == 0);
            apply_stimulus(src, w, r, a, 8'($urandom), ack, 0, 8'h00, "rand_read");
        end

        idle_cycle(8'h00);
        idle_cycle(8'h00);
        check_output("queue_drained", 8'(exp_q.size()), 8'h00);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
